// File: rtl/unidade_controle_jogo_pkg.sv
// unidade_controle_jogo_pkg: state codes, output bundle and Moore decoder for the memory-game controller
package unidade_controle_jogo_pkg;
   typedef enum logic [3:0] {
      INICIAL           = 4'h0,
      PREPARACAO        = 4'h1,
      INICIO_RODADA     = 4'h2,
      MOSTRA            = 4'h3,
      ZERA_TMR          = 4'h4,
      APAGA             = 4'h5,
      PROXIMO_MOSTRA    = 4'h6,
      FIM_MOSTRA        = 4'h7,
      ESPERA_JOGADA     = 4'h8,
      REGISTRA          = 4'h9,
      COMPARACAO        = 4'hA,
      PROXIMA_JOGADA    = 4'hB,
      PROXIMA_SEQUENCIA = 4'hC,
      FIM_ACERTOU       = 4'hD,
      FIM_ERROU         = 4'hE,
      FIM_TIMEOUT       = 4'hF
   } estado_t;
   typedef struct packed {
      logic zera_r;
      logic zera_e;
      logic zera_s;
      logic zera_m;
      logic zera_tmr;
      logic registra_r;
      logic registra_m;
      logic conta_e;
      logic conta_s;
      logic conta_tmr;
      logic pronto;
      logic ganhou;
      logic perdeu;
      logic db_timeout;
   } saidas_t;
   function automatic saidas_t decodifica(estado_t e);
      saidas_t s;
      s = '0;
      case (e)
         PREPARACAO: begin
            s.zera_r = 1'b1;
            s.zera_e = 1'b1;
            s.zera_s = 1'b1;
            s.zera_m = 1'b1;
            s.zera_tmr = 1'b1;
         end
         INICIO_RODADA: begin
            s.zera_e = 1'b1;
            s.zera_tmr = 1'b1;
         end
         MOSTRA: begin
            s.registra_m = 1'b1;
            s.conta_tmr = 1'b1;
         end
         ZERA_TMR: begin
            s.zera_m = 1'b1;
            s.zera_tmr = 1'b1;
         end
         APAGA: s.conta_tmr = 1'b1;
         PROXIMO_MOSTRA: begin
            s.conta_e = 1'b1;
            s.zera_tmr = 1'b1;
         end
         FIM_MOSTRA: begin
            s.zera_e = 1'b1;
            s.zera_tmr = 1'b1;
            s.zera_m = 1'b1;
         end
         REGISTRA: s.registra_r = 1'b1;
         PROXIMA_JOGADA: s.conta_e = 1'b1;
         PROXIMA_SEQUENCIA: s.conta_s = 1'b1;
         FIM_ACERTOU: begin
            s.pronto = 1'b1;
            s.ganhou = 1'b1;
         end
         FIM_ERROU: begin
            s.pronto = 1'b1;
            s.perdeu = 1'b1;
         end
         FIM_TIMEOUT: begin
            s.pronto = 1'b1;
            s.perdeu = 1'b1;
            s.db_timeout = 1'b1;
         end
         default: s = '0;
      endcase
      return s;
   endfunction
endpackage

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore FSM sequencing replay, move capture and compare of the memory game
// Inputs: clock, reset (async high), iniciar, jogada_feita, chavesIgualMemoria,
//         enderecoIgualSequencia, fimS, fimTMR, timeout
// Outputs: datapath clears/loads/enables, pronto/ganhou/perdeu/db_timeout, db_estado
module unidade_controle_jogo
   import unidade_controle_jogo_pkg::*;
#(
   parameter bit SEM_MOSTRA = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada_feita,
   input  logic       chavesIgualMemoria,
   input  logic       enderecoIgualSequencia,
   input  logic       fimS,
   input  logic       fimTMR,
   input  logic       timeout,
   output logic       zeraR,
   output logic       zeraE,
   output logic       zeraS,
   output logic       zeraM,
   output logic       zeraTMR,
   output logic       registraR,
   output logic       registraM,
   output logic       contaE,
   output logic       contaS,
   output logic       contaTMR,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       db_timeout,
   output logic [3:0] db_estado
);
   estado_t estado, prox;
   saidas_t saidas;
   always_comb begin
      prox = INICIAL;
      case (estado)
         INICIAL:           prox = iniciar ? PREPARACAO : INICIAL;
         PREPARACAO:        prox = INICIO_RODADA;
         INICIO_RODADA:     prox = SEM_MOSTRA ? FIM_MOSTRA : MOSTRA;
         MOSTRA:            prox = fimTMR ? ZERA_TMR : MOSTRA;
         ZERA_TMR:          prox = APAGA;
         APAGA:             prox = !fimTMR ? APAGA : enderecoIgualSequencia ? FIM_MOSTRA : PROXIMO_MOSTRA;
         PROXIMO_MOSTRA:    prox = MOSTRA;
         FIM_MOSTRA:        prox = ESPERA_JOGADA;
         ESPERA_JOGADA:     prox = jogada_feita ? REGISTRA : timeout ? FIM_TIMEOUT : ESPERA_JOGADA;
         REGISTRA:          prox = COMPARACAO;
         COMPARACAO:        prox = !chavesIgualMemoria ? FIM_ERROU :
                                   !enderecoIgualSequencia ? PROXIMA_JOGADA :
                                   fimS ? FIM_ACERTOU : PROXIMA_SEQUENCIA;
         PROXIMA_JOGADA:    prox = ESPERA_JOGADA;
         PROXIMA_SEQUENCIA: prox = INICIO_RODADA;
         FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: prox = iniciar ? PREPARACAO : estado;
         default:           prox = INICIAL;
      endcase
   end
   // outputs are registered from the next state so they stay aligned with the state register
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         estado <= INICIAL;
         saidas <= '0;
      end else begin
         estado <= prox;
         saidas <= decodifica(prox);
      end
   assign {zeraR, zeraE, zeraS, zeraM, zeraTMR, registraR, registraM,
           contaE, contaS, contaTMR, pronto, ganhou, perdeu, db_timeout} = saidas;
   assign db_estado = estado;
endmodule
